// File: rtl/serial_sub_pkg.sv
// Shared types and one-bit subtract helpers for the bit-serial subtractor.
// Also used by the bench so the cell and any reference model share one definition.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  function automatic logic sub_diff(input logic x, input logic y, input logic c);
    return x ^ y ^ c;
  endfunction

  function automatic logic sub_borrow(input logic x, input logic y, input logic c);
    return (~x & y) | (~(x ^ y) & c);
  endfunction

  // Bit-counter width: max(1, clog2(width)).
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_n_if.sv
// Producer/consumer handshake bundle for serial_subtractor_n.
// The ovf signal exists only when SERIAL_SUB_OVERFLOW_EN is defined.
interface serial_subtractor_n_if #(
  parameter int unsigned WIDTH = 4
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             b_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             b_out;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, b_in, out_ready,
    input  in_ready, out_valid, diff, b_out, ovf
  );

  modport slave (
    input  in_valid, a, b, b_in, out_ready,
    output in_ready, out_valid, diff, b_out, ovf
  );
`else
  modport master (
    output in_valid, a, b, b_in, out_ready,
    input  in_ready, out_valid, diff, b_out
  );

  modport slave (
    input  in_valid, a, b, b_in, out_ready,
    output in_ready, out_valid, diff, b_out
  );
`endif

endinterface

// File: rtl/full_subtractor_1.sv
// Combinational one-bit full subtractor: d = x - y - c, c_out is the borrow.
module full_subtractor_1
  import serial_sub_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic c,
  output logic d,
  output logic c_out
);

  assign d     = sub_diff(x, y, c);
  assign c_out = sub_borrow(x, y, c);

endmodule

// File: rtl/serial_subtractor_n.sv
// Bit-serial WIDTH-bit subtractor (a - b - b_in), LSB first, valid/ready on both sides.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor_n
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input logic                clk,
  input logic                rst_n,
  serial_subtractor_n_if.slave bus
);

  localparam int unsigned     CntW    = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             b_out_q, b_out_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  logic             in_ready;
  logic             out_valid;
  logic             accept;
  logic             last_bit;
  logic             d_bit;
  logic             c_next;
  logic [WIDTH-1:0] diff_shift;

  assign accept   = bus.in_valid & in_ready;
  assign last_bit = (cnt_q == LastBit);

  full_subtractor_1 u_cell (
    .x     (a_sh_q[0]),
    .y     (b_sh_q[0]),
    .c     (borrow_q),
    .d     (d_bit),
    .c_out (c_next)
  );

  // New result bit enters at the MSB; after WIDTH shifts bit 0 holds the first difference bit.
  if (WIDTH == 1) begin : g_shift_w1
    assign diff_shift = d_bit;
  end else begin : g_shift_wn
    assign diff_shift = {d_bit, diff_q[WIDTH-1:1]};
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (bus.in_valid) state_d = StShift;
      end
      StShift: begin
        if (last_bit) state_d = StDone;
      end
      StDone: begin
        if (bus.out_ready) state_d = bus.in_valid ? StShift : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: in_ready is the only path from out_ready to an output.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      StIdle: in_ready = 1'b1;
      StDone: begin
        out_valid = 1'b1;
        in_ready  = bus.out_ready;
      end
      default: ;
    endcase
  end

  // Datapath next state.
  always_comb begin
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    b_out_d  = b_out_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif
    if (accept) begin
      a_sh_d   = bus.a;
      b_sh_d   = bus.b;
      borrow_d = bus.b_in;
      cnt_d    = '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_msb_d  = bus.a[WIDTH-1];
      b_msb_d  = bus.b[WIDTH-1];
`endif
    end else if (state_q == StShift) begin
      a_sh_d   = a_sh_q >> 1;
      b_sh_d   = b_sh_q >> 1;
      diff_d   = diff_shift;
      borrow_d = c_next;
      cnt_d    = cnt_q + CntW'(1);
      if (last_bit) begin
        b_out_d = c_next;
`ifdef SERIAL_SUB_OVERFLOW_EN
        // d_bit is the result MSB on the last shift cycle.
        ovf_d   = (a_msb_q ^ b_msb_q) & (a_msb_q ^ d_bit);
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      b_out_q  <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      b_out_q  <= b_out_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.diff      = diff_q;
  assign bus.b_out     = b_out_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
  assign bus.ovf       = ovf_q;
`endif

endmodule
